// File: rtl/speed_uart_tx.sv
// speed_uart_tx: 8N1 UART framer for speed samples with a one-entry pending buffer.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte (5-byte frame instead of 4).
module speed_uart_tx #(
  parameter int SYS_FREQ = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int WIDTH_SPEED = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic [1:0]             valid_Epass,
  input  logic                   done,
  output logic                   serial_data_out,
  output logic                   busy,
  output logic                   overflow
);
  localparam int DIV = SYS_FREQ / BAUD_RATE;
  localparam int CW = $clog2(DIV + 1);
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FW = 8 * NB;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_i, byte_i;
  logic [FW-1:0] frm, pend, smp;
  logic pend_v, tick, fin, launch, direct, cap, drop;

  function automatic logic [FW-1:0] pack(input logic [15:0] s, input logic [1:0] v);
    logic [31:0] b;
    b = {6'b0, v, s[7:0], s[15:8], 8'hAA};
`ifdef FRAME_CHECKSUM_EN
    return {b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0], b};
`else
    return b;
`endif
  endfunction

  assign smp = pack(16'(speed), valid_Epass);
  assign busy = state != IDLE || pend_v;

  // fin is the last cycle of the final stop bit; a done there chains straight into the next frame
  always_comb begin
    tick = cnt == CW'(DIV - 1);
    fin = state == STOP && tick && byte_i == 3'(NB - 1);
    launch = (state == IDLE || fin) && (done || pend_v);
    direct = launch && !pend_v;
    cap = done && !direct && (!pend_v || launch);
    drop = done && pend_v && !launch;
    state_n = state;
    case (state)
      IDLE:    state_n = launch ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && bit_i == 3'd7 ? STOP : DATA;
      STOP:    state_n = tick ? (fin && !launch ? IDLE : START) : STOP;
      default: state_n = IDLE;
    endcase
  end

  // the line is registered, so it trails the state by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_i <= '0;
      byte_i <= '0;
      frm <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      serial_data_out <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
      if (state == DATA && tick) begin
        bit_i <= bit_i + 1'b1;
        frm <= frm >> 1;
      end
      if (state == STOP && tick) byte_i <= fin ? '0 : byte_i + 1'b1;
      if (launch) frm <= pend_v ? pend : smp;
      if (cap) pend <= smp;
      pend_v <= cap || (pend_v && !launch);
      serial_data_out <= state == START ? 1'b0 : state == DATA ? frm[0] : 1'b1;
      overflow <= drop;
    end
  end
endmodule

// File: tb/tb_speed_uart_tx.sv
// tb_speed_uart_tx: self-checking bench for speed_uart_tx (line, busy, overflow per cycle plus decoded bytes).
module tb_speed_uart_tx;
  localparam int SF = 50000, BR = 4800, DIV = SF / BR, WS = 14;
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int L = NB * 10 * DIV;
  typedef struct packed {logic [13:0] sp; logic [1:0] v; logic [39:0] b;} vec_t;
  logic clk = 0, reset_n = 1, done = 0;
  logic [WS-1:0] speed = '0;
  logic [1:0] vep = '0;
  logic line, busy, ov;
  int checks = 0, errors = 0, edge_n = 0, ov_seen = 0, busy_cnt = 0, d0 = 0;
  int fs[$];
  logic [39:0] fb[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_b = '0;
  logic rx_on = 0;
  int rx_c = 0, rx_k = 0;
  vec_t tbl[4];

  speed_uart_tx #(.SYS_FREQ(SF), .BAUD_RATE(BR), .WIDTH_SPEED(WS)) dut (
    .clk(clk), .reset_n(reset_n), .speed(speed), .valid_Epass(vep), .done(done),
    .serial_data_out(line), .busy(busy), .overflow(ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s edge %0d: got %0h want %0h", nm, edge_n, act, exp);
    end
  endtask

  function automatic logic [39:0] frame_of(input int sp, input int v);
    logic [7:0] b1, b2, b3;
    b1 = 8'(sp >> 8);
    b2 = 8'(sp);
    b3 = 8'(v);
    return {8'hAA ^ b1 ^ b2 ^ b3, b3, b2, b1, 8'hAA};
  endfunction

  // frame i occupies the line from edge fs[i] for L cycles, 10 bits per byte
  function automatic logic exp_line(input int e);
    foreach (fs[i]) if (e >= fs[i] && e < fs[i] + L) begin
      int k = (e - fs[i]) / DIV;
      int j = k % 10;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return fb[i][(k / 10) * 8 + j - 1];
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int e);
    foreach (fs[i]) if (e >= fs[i] - 1 && e < fs[i] - 1 + L) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_done(input int sp, input int v, output logic eo);
    int c = 0;
    eo = 1'b0;
    foreach (fs[i]) if (fs[i] - 1 + L > edge_n) c++;
    if (c == 0) fs.push_back(edge_n + 1);
    else if (c == 1) fs.push_back(fs[fs.size() - 1] + L);
    else eo = 1'b1;
    if (c < 2) fb.push_back(frame_of(sp, v));
  endtask

  task automatic tick(input logic d, input logic [WS-1:0] sp, input logic [1:0] v);
    logic eo = 1'b0;
    done = d;
    speed = sp;
    vep = v;
    @(posedge clk);
    edge_n++;
    if (d && reset_n) model_done(int'(sp), int'(v), eo);
    @(negedge clk);
    done = 0;
    check("line", 64'(line), 64'(exp_line(edge_n)));
    check("busy", 64'(busy), 64'(exp_busy(edge_n)));
    check("overflow", 64'(ov), 64'(eo));
    if (ov === 1'b1) ov_seen++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, WS'($urandom), 2'($urandom));
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy === 1'b1 && n < lim) begin
      idle(1);
      n++;
    end
    check("idle_timeout", 64'(n < lim), 64'd1);
    idle(2);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 0;
    #1;
    check("rst_line", 64'(line), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ov), 64'd0);
    fs.delete();
    fb.delete();
    rx_q.delete();
    idle(3);
    reset_n = 1;
  endtask

  task automatic run_vec(input int i);
    rx_q.delete();
    busy_cnt = 0;
    tick(1'b1, tbl[i].sp, tbl[i].v);
    wait_idle(L + 20);
    check("frame_len", 64'(busy_cnt), 64'(L));
    check("rx_count", 64'(rx_q.size()), 64'(NB));
    for (int k = 0; k < NB; k++)
      check("byte", 64'(rx_q.size() > k ? rx_q[k] : 8'hxx), 64'(tbl[i].b[8*k +: 8]));
  endtask

  // independent UART receiver sampling mid-bit
  always @(negedge clk) begin
    if (!reset_n) rx_on = 0;
    else if (!rx_on) begin
      if (line === 1'b0) begin
        rx_on = 1;
        rx_c = 0;
      end
    end else begin
      rx_c++;
      if (rx_c % DIV == DIV / 2) begin
        rx_k = rx_c / DIV;
        if (rx_k >= 1 && rx_k <= 8) rx_b[rx_k-1] = line;
        if (rx_k == 9) begin
          check("stop_bit", 64'(line), 64'd1);
          rx_q.push_back(rx_b);
          rx_on = 0;
        end
      end
    end
  end

  initial begin
    tbl[0] = '{14'd225,   2'b10, 40'h49_02_E1_00_AA};
    tbl[1] = '{14'h3FFF,  2'b00, 40'h6A_00_FF_3F_AA};
    tbl[2] = '{14'd0,     2'b11, 40'hA9_03_00_00_AA};
    tbl[3] = '{14'h1234,  2'b01, 40'h8D_01_34_12_AA};
    #1 reset_n = 0;
    #1;
    check("rst0_line", 64'(line), 64'd1);
    check("rst0_busy", 64'(busy), 64'd0);
    check("rst0_ovf", 64'(ov), 64'd0);
    idle(10);
    reset_n = 1;
    idle(5);
    foreach (tbl[i]) run_vec(i);
    // three requests while busy: second queued back-to-back, third dropped
    rx_q.delete();
    ov_seen = 0;
    tick(1'b1, 14'd100, 2'd1);
    idle(99);
    tick(1'b1, 14'd200, 2'd2);
    idle(99);
    tick(1'b1, 14'd300, 2'd3);
    check("ovf_pulse", 64'(ov), 64'd1);
    wait_idle(3 * L);
    check("ovf_count", 64'(ov_seen), 64'd1);
    check("two_frames", 64'(rx_q.size()), 64'(2 * NB));
    check("f1_lo", 64'(rx_q.size() > 2 ? rx_q[2] : 8'hxx), 64'h64);
    check("f2_lo", 64'(rx_q.size() > NB + 2 ? rx_q[NB+2] : 8'hxx), 64'hC8);
    // reset during data bit 3 of byte 2, then a clean frame
    tick(1'b1, 14'h2A5C, 2'd1);
    idle(245);
    pulse_reset();
    idle(5);
    run_vec(1);
    // done on the final cycle of the last stop bit
    ov_seen = 0;
    tick(1'b1, 14'd5, 2'd1);
    d0 = edge_n;
    idle(L - 1);
    tick(1'b1, 14'd6, 2'd2);
    idle(1);
    check("b2b_start", 64'(line), 64'd0);
    wait_idle(2 * L);
    // same corner with the pending buffer already full
    rx_q.delete();
    tick(1'b1, 14'd7, 2'd0);
    idle(49);
    tick(1'b1, 14'd8, 2'd1);
    idle(L - 51);
    tick(1'b1, 14'd9, 2'd2);
    wait_idle(3 * L);
    check("corner_ovf", 64'(ov_seen), 64'd0);
    check("three_frames", 64'(rx_q.size()), 64'(3 * NB));
    check("f3_lo", 64'(rx_q.size() > 2 * NB + 2 ? rx_q[2*NB+2] : 8'hxx), 64'h09);
    repeat (4000) tick(1'($urandom_range(0, 149) == 0), WS'($urandom), 2'($urandom));
    wait_idle(3 * L);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/speed_uart_tx.md
SPEED_UART_TX -- requirements
Module: speed_uart_tx

Interface
REQ-001 Parameter SYS_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 Parameter WIDTH_SPEED, default 14: speed result width; legal range 1..16.
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port speed  input  WIDTH_SPEED  measured speed from the speed-measurement stage; valid only when done=1.
REQ-007 Port valid_Epass  input  2  E-pass status sampled together with speed.
REQ-008 Port done  input  1  one-cycle pulse marking a new measurement.
REQ-009 Port serial_data_out  output  1  UART TX line, 8N1, LSB first, idle high.
REQ-010 Port busy  output  1  high while a frame is being shifted or one is pending.
REQ-011 Port overflow  output  1  one-cycle pulse when a measurement is dropped.

Function
REQ-012 Bit period SHALL be DIV = SYS_FREQ/BAUD_RATE clock cycles (integer truncation; 434 at defaults), counted by an internal baud counter that restarts at each start bit.
REQ-013 Frame SHALL be bytes in order: 0xAA header, speed[15:8], speed[7:0], status {6'b0, valid_Epass}, then checksum (see Configuration); speed zero-extended to 16 bits.
REQ-014 Each byte SHALL be one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly DIV cycles.
REQ-015 Bytes of one frame SHALL be back-to-back: next start bit immediately follows previous stop bit.
REQ-016 State machine states: IDLE, START, DATA, STOP; byte index 0..N-1 and bit index 0..7 held in counters.
REQ-017 IDLE -> START on done=1 (or pending entry present); START -> DATA after DIV cycles; DATA -> STOP after 8th bit; STOP -> START if bytes remain or pending entry present, else IDLE.
REQ-018 Latency: serial_data_out SHALL drop low on the first rising edge after the edge sampling done=1 in IDLE.
REQ-019 speed and valid_Epass SHALL be captured into a frame register on the done edge; later input changes SHALL NOT affect the frame in flight.
REQ-020 One-entry pending buffer: done while transmitting with buffer empty SHALL capture speed/valid_Epass into it; that frame starts immediately after the current frame's last stop bit.
REQ-021 done while transmitting with buffer full SHALL drop the new sample, keep the buffered one, and pulse overflow for exactly one cycle.
REQ-022 done coinciding with the last cycle of the final stop bit SHALL be captured into the pending buffer (never dropped).
REQ-023 busy SHALL be 1 from the cycle after done is sampled until the final stop bit of the last pending frame completes.

Reset
REQ-024 reset_n low SHALL immediately force serial_data_out=1, busy=0, overflow=0, state IDLE, all counters 0, pending buffer empty.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no partial byte resumes after release.

Configuration
REQ-026 Macro FRAME_CHECKSUM_EN defined: frame is 5 bytes, fifth byte = XOR of the four preceding bytes.
REQ-027 Macro FRAME_CHECKSUM_EN undefined: frame is 4 bytes, no checksum byte; all other behaviour unchanged.

Verification
REQ-028 Reset with reset_n=0 -> serial_data_out=1, busy=0, overflow=0; hold 10 cycles, line stays high.
REQ-029 done with speed=14'd225, valid_Epass=2'b10 (checksum on) -> bytes AA 00 E1 02 49, each bit 434 cycles, 21700 cycles total, busy falls after last stop bit.
REQ-030 done with speed=14'h3FFF, valid_Epass=2'b00 -> bytes AA 3F FF 00 6A; checksum off -> AA 3F FF 00 only, 17360 cycles.
REQ-031 Three done pulses 1000 cycles apart -> frames 1 and 2 sent back-to-back with no idle gap, third dropped, overflow pulses one cycle at third done.
REQ-032 reset_n pulsed low during data bit 3 of byte 2 -> line high immediately, busy=0; next done produces a complete correct frame.
REQ-033 done on the final cycle of the last stop bit -> new frame start bit begins next cycle, overflow stays 0.
